count_enable_sequencer: RTL and testbench
=========================================

# count_enable_sequencer

Run-length sequencer that sits directly upstream of the partitioned binary counter and drives its `enable` input. A start request opens a window of exactly `RUN_LEN` enabled clock cycles, so the counter advances by `RUN_LEN`. The window can be paused, resumed and aborted, and its end is flagged with a one-cycle `done` strobe. All outputs are registered Moore outputs of a four-state ASM controller.

## Interface
- `RUN_LEN`, default 12: enabled cycles per run; legal range 1..2^RUN_W-1.
- `RUN_W`, default 4: width of the remaining-cycles counter; matches the downstream counter `size`.
- `clk` input, 1 bit: single system clock; everything is sampled on the rising edge.
- `rst_b` input, 1 bit: reset; asynchronous, active-low.
- `start` input, 1 bit: run request.
- `pause` input, 1 bit: level-sensitive hold request.
- `stop` input, 1 bit: abort request.
- `enable` output, 1 bit: count enable to the downstream counter.
- `busy` output, 1 bit: high in RUN or PAUSE.
- `done` output, 1 bit: one-cycle strobe at the end of a completed run.
- `remaining` output, RUN_W bits: enabled cycles still owed in the current run.

## Operation
- States: S_IDLE, S_RUN, S_PAUSE, S_DONE.
- Output decode: `enable` is 1 only in S_RUN. `busy` is 1 in S_RUN or S_PAUSE. `done` is 1 only in S_DONE.
- Priority: `stop` > `pause` > `start`.
- **S_IDLE:**
  - `start` and not `stop`: go to S_RUN and load `remaining` with RUN_LEN.
  - Otherwise: stay.
- **S_RUN:** every cycle `remaining` decrements.
  - `remaining`==1: go to S_DONE. This beats `pause`; it does not beat `stop`.
  - `stop`: go to S_IDLE and clear `remaining` to 0.
  - `pause`: go to S_PAUSE.
  - `start`: ignored.
- **S_PAUSE:** `remaining` is frozen.
  - `stop`: go to S_IDLE and clear `remaining`.
  - `pause` low: go to S_RUN.
  - `pause` high: stay.
- **S_DONE:** unconditionally go to S_IDLE after one cycle. `remaining` is 0.
- Run length: an uninterrupted run gives exactly RUN_LEN consecutive `enable`-high cycles. Pauses split the run but never change the total.
- Stop: the cycle in which `stop` is sampled still has `enable` high. No `done` is issued after a stop.
- Width rule: `remaining` is unsigned RUN_W bits. It never underflows, because the decrement happens only in S_RUN, where `remaining` is ≥1.

## Timing
- Reset values: state S_IDLE, `enable`=0, `busy`=0, `done`=0, `remaining`=0.
- Reset behaviour: these values apply asynchronously on `rst_b` falling, including mid-run. The block leaves reset on the first rising edge with `rst_b` high.
- Start latency: `start` sampled at edge k gives `enable` high from edge k through edge k+RUN_LEN.
- Done timing: `done` is high for one cycle starting at edge k+RUN_LEN.
- Back-to-back runs: the earliest next start is the cycle after S_DONE. This leaves a minimum `enable`-low gap of 2 cycles.
- Pause/stop latency: `enable` falls one edge after `pause` or `stop` is sampled high. After `pause` is sampled low, `enable` rises at the next edge.

## Configuration
- `START_SYNC_EN`:
  - Defined: `start` passes through a two-flop synchronizer, then a rising-edge detector. Start latency grows by 2 cycles, and a held-high `start` launches only one run.
  - Undefined: `start` is treated as a synchronous level and sampled directly. A `start` still high in the cycle after S_DONE launches a new run.

## Structure
- Shared package `count_seq_pkg` holds:
  - the state encoding constants (2-bit binary: S_IDLE=0, S_RUN=1, S_PAUSE=2, S_DONE=3);
  - the default RUN_W.
- Sub-module `run_length_counter` is the datapath. It holds the `remaining` register with load, decrement, clear and hold, and exposes an `is_one` flag.
- The top level holds the controller and the optional start synchronizer, matching the control/datapath partition of the downstream counter.

## Test plan
1. **Reset:** `rst_b`=0 at t=2 with all inputs 0 → `enable`=0, `busy`=0, `done`=0, `remaining`=0 before the first clock edge.
2. **Plain run:** one-cycle `start` → `enable` high exactly 12 cycles; downstream count goes 0→4'hC; `done` high exactly 1 cycle immediately after the last `enable` cycle; `busy` falls with `done`.
3. **Pause:** `pause` high for 3 cycles starting at the 6th `enable` cycle → `enable` low for 3 cycles; `remaining` frozen at 6; 12 total `enable` cycles; final count 4'hC.
4. **Stop:** `stop` pulsed while `remaining`=4 → `enable` low at the next edge; state S_IDLE; `remaining`=0; no `done`; final count 4'h9.
5. **Simultaneous requests:**
   - `start`+`stop` together in S_IDLE → no run.
   - `start` repulsed during S_RUN → run length unchanged.
   - `pause` and `remaining`==1 together → S_DONE, not S_PAUSE.
6. **Reset mid-run:** `rst_b` low at `remaining`=7 → all outputs 0 asynchronously; a later `start` yields a full 12-cycle run. With `START_SYNC_EN` defined, `start` held high for 40 cycles → exactly one run, first `enable` 2 cycles later than without the macro.

Source files
------------

// File: rtl/count_enable_sequencer_pkg.sv
// Shared state encoding and default sizing for the count-enable sequencer
// and its run-length datapath.
package count_seq_pkg;

  localparam int DEFAULT_RUN_W   = 4;
  localparam int DEFAULT_RUN_LEN = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/count_enable_sequencer_if.sv
// Request/status bundle between a run requester (master) and the
// count-enable sequencer (slave).
interface count_enable_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int RUN_W = DEFAULT_RUN_W
);

  logic             start;
  logic             pause;
  logic             stop;
  logic             enable;
  logic             busy;
  logic             done;
  logic [RUN_W-1:0] remaining;

  modport master (
    output start, pause, stop,
    input  enable, busy, done, remaining
  );

  modport slave (
    input  start, pause, stop,
    output enable, busy, done, remaining
  );

endinterface

// File: rtl/count_enable_sequencer_run_length_counter.sv
// Remaining-cycles register of the sequencer: load, decrement, clear or hold,
// with a flag marking the last owed cycle.
module run_length_counter
  import count_seq_pkg::*;
#(
  parameter int RUN_W   = DEFAULT_RUN_W,
  parameter int RUN_LEN = DEFAULT_RUN_LEN
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  output logic [RUN_W-1:0] count,
  output logic             is_one
);

  localparam logic [RUN_W-1:0] LOAD_VAL = RUN_W'(RUN_LEN);

  // Clear wins so an abort always leaves nothing owed.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec) begin
      count <= count - RUN_W'(1);
    end
  end

  assign is_one = (count == RUN_W'(1));

endmodule

// File: rtl/count_enable_sequencer.sv
// Run-length controller driving a downstream counter enable.
// Optional `START_SYNC_EN: synchronise start and launch on its rising edge only.
module count_enable_sequencer
  import count_seq_pkg::*;
#(
  parameter int RUN_LEN = DEFAULT_RUN_LEN,
  parameter int RUN_W   = DEFAULT_RUN_W
) (
  input  logic                     clk,
  input  logic                     rst_b,
  count_enable_sequencer_if.slave  bus
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             start_go;
  logic             load;
  logic             dec;
  logic             clr;
  logic             is_one;
  logic [RUN_W-1:0] count;

`ifdef START_SYNC_EN
  logic [2:0] start_sync;

  // Two synchroniser stages plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      start_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], bus.start};
    end
  end

  assign start_go = start_sync[1] & ~start_sync[2];
`else
  assign start_go = bus.start;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    clr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_go && !bus.stop) begin
          state_nxt = S_RUN;
          load      = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
          clr       = 1'b1;
        end else begin
          // The last owed cycle finishes the run even if pause arrives with it.
          dec = 1'b1;
          if (is_one) begin
            state_nxt = S_DONE;
          end else if (bus.pause) begin
            state_nxt = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
          clr       = 1'b1;
        end else if (!bus.pause) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state flops.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bus.enable <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.enable <= (state_nxt == S_RUN);
      bus.busy   <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
      bus.done   <= (state_nxt == S_DONE);
    end
  end

  run_length_counter #(
    .RUN_W   (RUN_W),
    .RUN_LEN (RUN_LEN)
  ) u_run_length_counter (
    .clk    (clk),
    .rst_b  (rst_b),
    .load   (load),
    .dec    (dec),
    .clr    (clr),
    .count  (count),
    .is_one (is_one)
  );

  assign bus.remaining = count;

endmodule

// File: tb/tb_count_enable_sequencer.sv
// Self-checking bench for count_enable_sequencer: directed scenarios plus
// random traffic against a run-bookkeeping reference model.
module tb_count_enable_sequencer;

  localparam int RUN_LEN = 12;
  localparam int RUN_W   = 4;
`ifdef START_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_b = 1'b1;

  count_enable_sequencer_if #(.RUN_W(RUN_W)) bus ();

  count_enable_sequencer #(
    .RUN_LEN (RUN_LEN),
    .RUN_W   (RUN_W)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int       assertCount = 0;
  int       failCount   = 0;

  // Reference model: cycles still owed, whether the run is held, done strobe.
  int       owed;
  bit       halted;
  bit       doneStrobe;
  logic [2:0] hist;

  // Downstream counter emulation and done-strobe tally.
  logic [3:0] cnt;
  int         doneSeen;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    owed       = 0;
    halted     = 1'b0;
    doneStrobe = 1'b0;
    hist       = '0;
  endtask

  task automatic modelStep(input bit st, input bit pa, input bit sp);
    bit eff;
`ifdef START_SYNC_EN
    eff = hist[1] & ~hist[2];
`else
    eff = st;
`endif
    hist = {hist[1:0], st};
    if (doneStrobe) begin
      doneStrobe = 1'b0;
    end else if (owed == 0) begin
      if (eff && !sp) owed = RUN_LEN;
    end else if (sp) begin
      owed   = 0;
      halted = 1'b0;
    end else if (halted) begin
      if (!pa) halted = 1'b0;
    end else begin
      owed--;
      if (owed == 0) doneStrobe = 1'b1;
      else if (pa) halted = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("enable", 32'(bus.enable), 32'(owed > 0 && !halted));
    checkOutput("busy", 32'(bus.busy), 32'(owed > 0));
    checkOutput("done", 32'(bus.done), 32'(doneStrobe));
    checkOutput("remaining", 32'(bus.remaining), 32'(owed));
  endtask

  task automatic applyStimulus(input bit st, input bit pa, input bit sp);
    @(negedge clk);
    compareAll();
    if (bus.enable === 1'b1) cnt++;
    if (bus.done === 1'b1) doneSeen++;
    bus.start = st;
    bus.pause = pa;
    bus.stop  = sp;
    @(posedge clk);
    modelStep(st, pa, sp);
  endtask

  task automatic clearTally();
    cnt      = '0;
    doneSeen = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    modelReset();
    clearTally();

    // Asynchronous reset before any clock edge.
    #2 rst_b = 1'b0;
    #1;
    checkOutput("rst_enable", 32'(bus.enable), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_remaining", 32'(bus.remaining), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;

    $display("[TB] plain run");
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 4; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0);
      if (i == SYNC_LAT) begin
        #1 checkOutput("first_enable", 32'(bus.enable), 32'd1);
      end
    end
    checkOutput("plain_count", 32'(cnt), 32'hC);
    checkOutput("plain_done", 32'(doneSeen), 32'd1);

    $display("[TB] pause mid-run");
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 8; i++) begin
      applyStimulus(i == 0, (i >= 6 + SYNC_LAT) && (i <= 8 + SYNC_LAT), 1'b0);
      if (i == 7 + SYNC_LAT) begin
        #1;
        checkOutput("pause_frozen", 32'(bus.remaining), 32'd6);
        checkOutput("pause_enable", 32'(bus.enable), 32'd0);
      end
    end
    checkOutput("pause_count", 32'(cnt), 32'hC);
    checkOutput("pause_done", 32'(doneSeen), 32'd1);

    $display("[TB] stop at remaining 4");
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 4; i++) begin
      applyStimulus(i == 0, 1'b0, i == 9 + SYNC_LAT);
      if (i == 9 + SYNC_LAT) begin
        #1;
        checkOutput("stop_remaining", 32'(bus.remaining), 32'd0);
        checkOutput("stop_enable", 32'(bus.enable), 32'd0);
        checkOutput("stop_busy", 32'(bus.busy), 32'd0);
      end
    end
    checkOutput("stop_count", 32'(cnt), 32'h9);
    checkOutput("stop_done", 32'(doneSeen), 32'd0);

    $display("[TB] start with stop in idle");
    clearTally();
    for (int i = 0; i < SYNC_LAT + 6; i++) begin
      applyStimulus(i == 0, 1'b0, i == SYNC_LAT);
    end
    checkOutput("startstop_count", 32'(cnt), 32'd0);
    checkOutput("startstop_busy", 32'(bus.busy), 32'd0);

    $display("[TB] start repulsed during run");
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 6; i++) begin
      applyStimulus((i == 0) || (i == 5 + SYNC_LAT), 1'b0, 1'b0);
    end
    checkOutput("repulse_count", 32'(cnt), 32'hC);
    checkOutput("repulse_done", 32'(doneSeen), 32'd1);

    $display("[TB] pause on last cycle");
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 4; i++) begin
      applyStimulus(i == 0, i == 12 + SYNC_LAT, 1'b0);
      if (i == 12 + SYNC_LAT) begin
        #1;
        checkOutput("lastpause_done", 32'(bus.done), 32'd1);
        checkOutput("lastpause_busy", 32'(bus.busy), 32'd0);
      end
    end
    checkOutput("lastpause_count", 32'(cnt), 32'hC);

    $display("[TB] reset mid-run");
    for (int i = 0; i <= 5 + SYNC_LAT; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0);
    end
    #1 checkOutput("midrun_remaining_before", 32'(bus.remaining), 32'd7);
    #1 rst_b = 1'b0;
    #1;
    checkOutput("midrun_rst_enable", 32'(bus.enable), 32'd0);
    checkOutput("midrun_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrun_rst_done", 32'(bus.done), 32'd0);
    checkOutput("midrun_rst_remaining", 32'(bus.remaining), 32'd0);
    modelReset();
    @(negedge clk);
    rst_b = 1'b1;
    clearTally();
    for (int i = 0; i < RUN_LEN + SYNC_LAT + 4; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0);
    end
    checkOutput("postrst_count", 32'(cnt), 32'hC);
    checkOutput("postrst_done", 32'(doneSeen), 32'd1);

`ifdef START_SYNC_EN
    $display("[TB] held start launches one run");
    clearTally();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("held_count", 32'(cnt), 32'hC);
    checkOutput("held_done", 32'(doneSeen), 32'd1);
`else
    $display("[TB] held start relaunches after done");
    clearTally();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("held_count", 32'(cnt), 32'h4);
    checkOutput("held_done", 32'(doneSeen), 32'd3);
`endif

    $display("[TB] random traffic");
    begin
      bit pa;
      pa = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) pa = ~pa;
        applyStimulus($urandom_range(0, 7) == 0, pa, $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
